// File: rtl/binary_add_arbiter.sv
// binary_add_arbiter: round-robin arbiter that time-shares one W-bit adder
// among NREQ requesters. Each grant takes three cycles: grant/capture,
// add, and hold until the consumer accepts the tagged result.
// Optional feature macro: ADD_ARB_CARRY_EN adds a registered res_carry_o
// output carrying the adder's carry-out.
module binary_add_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 14,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid_i,
    output logic [NREQ-1:0]   req_ready_o,
    input  logic [NREQ*W-1:0] req_a_i,
    input  logic [NREQ*W-1:0] req_b_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [W-1:0]      res_sum_o,
    output logic [IDW-1:0]    res_id_o
`ifdef ADD_ARB_CARRY_EN
    ,
    output logic              res_carry_o
`endif
);

`ifdef ADD_ARB_CARRY_EN
    localparam int unsigned AW = W + 1;
`else
    localparam int unsigned AW = W;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q;
    logic [IDW-1:0]   ptr_q;
    logic [IDW-1:0]   g_q;
    logic [W-1:0]     op_a_q;
    logic [W-1:0]     op_b_q;
    logic             res_valid_q;
    logic [W-1:0]     res_sum_q;
    logic [IDW-1:0]   res_id_q;
`ifdef ADD_ARB_CARRY_EN
    logic             res_carry_q;
`endif

    logic [W-1:0]     a_arr [NREQ];
    logic [W-1:0]     b_arr [NREQ];
    logic             gnt_found;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW-1:0]   ptr_nxt;
    logic [AW-1:0]    sum_full;

    // Unpack the flat operand buses into per-requester words.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a_i[gi*W +: W];
        assign b_arr[gi] = req_b_i[gi*W +: W];
    end

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        int unsigned cand;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = (32'(ptr_q) + k) % NREQ;
            if (!gnt_found && req_valid_i[IDW'(cand)]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(cand);
            end
        end
    end

    // One-hot grant, only offered while idle and out of reset.
    always_comb begin
        req_ready_o = '0;
        if (rst_n && (state_q == ST_IDLE) && gnt_found) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Shared adder; the extra MSB exists only when the carry is exported.
    always_comb begin
        sum_full = AW'(op_a_q) + AW'(op_b_q);
    end

    // Pointer moves past the served requester, wrapping explicitly at NREQ-1.
    always_comb begin
        if (g_q == IDW'(NREQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = g_q + IDW'(1);
        end
    end

    // Sequencer: capture winner, add, then hold the result until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            g_q         <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            res_valid_q <= 1'b0;
            res_sum_q   <= '0;
            res_id_q    <= '0;
`ifdef ADD_ARB_CARRY_EN
            res_carry_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (gnt_found) begin
                        op_a_q  <= a_arr[gnt_idx];
                        op_b_q  <= b_arr[gnt_idx];
                        g_q     <= gnt_idx;
                        state_q <= ST_ADD;
                    end
                end
                ST_ADD: begin
                    res_sum_q   <= sum_full[W-1:0];
                    res_id_q    <= g_q;
                    res_valid_q <= 1'b1;
`ifdef ADD_ARB_CARRY_EN
                    res_carry_q <= sum_full[AW-1];
`endif
                    state_q     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (res_ready_i) begin
                        res_valid_q <= 1'b0;
                        ptr_q       <= ptr_nxt;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign res_valid_o = res_valid_q;
    assign res_sum_o   = res_sum_q;
    assign res_id_o    = res_id_q;
`ifdef ADD_ARB_CARRY_EN
    assign res_carry_o = res_carry_q;
`endif

endmodule

// File: doc/binary_add_arbiter.md
# binary_add_arbiter

Round-robin arbiter and sequencer that shares one W-bit ripple-carry adder datapath among NREQ requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester at a time, registers its operands, and performs the addition in a dedicated adder cycle. It returns the sum tagged with the requester index over a result valid/ready handshake. It sits between the client ports and the shared adder, and replaces per-client adder instances.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..16)
- W, 14, operand and sum width
- IDW, $clog2(NREQ), width of the requester index

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  bit i: requester i has an operand pair pending
- req_ready  out  NREQ  bit i: requester i's pair is accepted this cycle (one-hot or zero)
- req_a  in  NREQ*W  operand A of requester i at bits [i*W +: W]
- req_b  in  NREQ*W  operand B of requester i at bits [i*W +: W]
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_sum  out  W  (A+B) mod 2^W
- res_id  out  IDW  index of the requester that produced res_sum
- res_carry  out  1  carry-out of the addition; present only with ADD_ARB_CARRY_EN

## Operation
- FSM states: IDLE, ADD, HOLD. Reset state is IDLE.
- IDLE:
  - req_ready is combinational. It is a one-hot grant to the first requester with req_valid=1, searching from index ptr upward with wrap to 0.
  - If any req_valid is high, the winner's req_a/req_b are captured into op_a/op_b, its index g is captured, and the FSM moves to ADD.
  - If no req_valid is high, the FSM stays in IDLE and req_ready=0.
- ADD:
  - res_sum <= op_a + op_b, truncated to W bits.
  - res_id <= g; res_valid <= 1.
  - The FSM moves to HOLD.
  - req_ready=0.
- HOLD:
  - res_valid, res_sum and res_id stay stable until res_ready=1.
  - On the res_valid && res_ready cycle: res_valid <= 0, ptr <= (g+1) mod NREQ, and the FSM moves to IDLE.
  - req_ready=0 throughout HOLD.
- Requester rule: once req_valid is asserted, the requester holds it and its operands stable until its req_ready. A requester that deasserts req_valid before being granted is legal and simply loses arbitration.
- Fairness: ptr advances only on result acceptance. With all requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.
- Overflow: the sum wraps modulo 2^W. Without the configuration macro, no flag is produced.
- ptr is IDW bits. When NREQ is not a power of 2, the increment wraps explicitly from NREQ-1 to 0.

## Timing
- Reset values: req_ready=0, res_valid=0, res_sum=0, res_id=0, res_carry=0 (if present), ptr=0, state=IDLE.
- Latency: a grant in cycle T gives res_valid=1 in cycle T+2.
- Throughput: one result per 3 cycles when res_ready is held at 1 (grant, add, accept). Result acceptance in cycle T+2 allows the next grant in cycle T+3.
- res_ready=1 while in IDLE or ADD has no effect.
- Simultaneous requests: exactly one grant per IDLE cycle. Non-granted requesters wait.
- Reset asserted mid-operation (ADD or HOLD): the in-flight transaction is discarded and no result is emitted. All outputs go to their reset values immediately (asynchronous reset).
- res_ready held low indefinitely: the FSM stays in HOLD and the outputs stay stable. No new grants are issued.

## Configuration
- Macro: ADD_ARB_CARRY_EN.
- Defined:
  - The adder is W+1 bits wide and the MSB is registered to res_carry in ADD.
  - res_carry follows the same stability and reset rules as res_sum.
- Undefined:
  - The res_carry port and its register are absent.
  - The carry-out is discarded.

## Test plan
- Reset, then a single request: req0 A=14'd100, B=14'd23, res_ready=1 -> req_ready[0] in cycle T, res_valid in cycle T+2 with res_sum=123 and res_id=0, IDLE in cycle T+3.
- All four requesters valid continuously with distinct operands, res_ready=1 -> grant order 0,1,2,3,0, each with the correct sum and res_id. No requester is granted twice before the others.
- Wrap: A=14'h3FFF, B=14'h0002 -> res_sum=14'h0001. With ADD_ARB_CARRY_EN, res_carry=1. Without it, there is no carry port.
- Backpressure: res_ready=0 for 10 cycles after res_valid while req1..3 are valid -> res_sum and res_id stay stable, req_ready stays 0, and the next grant occurs one cycle after res_ready goes high.
- Reset mid-operation: assert rst_n=0 in HOLD -> res_valid drops to 0 immediately. After release, no stale result appears and ptr restarts at 0.
- Withdrawn request: req2 deasserts valid while req0 is being served -> the next grant goes to req3 (or wraps to req0), never to req2.
